// File: rtl/lpf_fir_stage.sv
// Single-MAC time-multiplexed FIR low-pass filter, Q1.15 coefficients, round + saturate to DW.
// Latency: out_valid in cycle TAPS+2 after acceptance (1 cycle when bypassed); one sample per TAPS+2 cycles.
// Backpressure: none; in_valid while busy drops the sample and sets sticky overrun. Option macro: LPF_BYPASS_EN.
module lpf_fir_stage #(
    parameter int TAPS = 16,
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int ACCW = 40,
    localparam int AW  = $clog2(TAPS)
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          in_valid,
    input  logic [DW-1:0] data_in,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [CW-1:0] coef_data,
    input  logic          ovr_clr,
`ifdef LPF_BYPASS_EN
    input  logic          bypass,
`endif
    output logic [DW-1:0] data_out,
    output logic          out_valid,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

    localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(64'sd1 <<< (CW-2));
    localparam logic signed [ACCW-1:0] SAT_MAX  = ACCW'((64'sd1 <<< (DW-1)) - 64'sd1);
    localparam logic signed [ACCW-1:0] SAT_MIN  = ~SAT_MAX;

    state_t                  state, state_nxt;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           k;
    logic [AW-1:0]           rd_idx;
    logic [DW-1:0]           delay_line [TAPS];
    logic [CW-1:0]           coef [TAPS];
    logic [DW-1:0]           x_k;
    logic [CW-1:0]           h_k;
    logic [DW+CW-1:0]        prod;
    logic signed [ACCW-1:0]  acc, prod_ext, rnd, shifted;
    logic [DW-1:0]           sat;
    logic                    byp;

`ifdef LPF_BYPASS_EN
    assign byp = bypass;
`else
    assign byp = 1'b0;
`endif

    assign busy   = (state != IDLE);
    assign rd_idx = wr_ptr - k;
    assign x_k    = delay_line[rd_idx];
    assign h_k    = coef[k];

    // Low DW+CW bits of the product of sign-extended operands equal the signed product.
    assign prod     = {{CW{x_k[DW-1]}}, x_k} * {{DW{h_k[CW-1]}}, h_k};
    assign prod_ext = {{(ACCW-DW-CW){prod[DW+CW-1]}}, prod};
    assign rnd      = acc + RND_HALF;
    assign shifted  = rnd >>> (CW-1);

    always_comb begin
        sat = shifted[DW-1:0];
        if (shifted > SAT_MAX)
            sat = SAT_MAX[DW-1:0];
        else if (shifted < SAT_MIN)
            sat = SAT_MIN[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && !byp) state_nxt = MAC;
            MAC:     if (k == AW'(TAPS-1)) state_nxt = ROUND;
            ROUND:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            wr_ptr    <= '0;
            k         <= '0;
            acc       <= '0;
            for (int i = 0; i < TAPS; i++) begin
                delay_line[i] <= '0;
                coef[i]       <= CW'(2048);
            end
        end else begin
            out_valid <= 1'b0;

            if (in_valid && busy)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;

            // Coefficient write lands before the MAC run that starts next cycle.
            if (coef_we && !busy)
                coef[coef_addr] <= coef_data;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        delay_line[wr_ptr] <= data_in;
                        acc <= '0;
                        k   <= '0;
                        if (byp) begin
                            data_out  <= data_in;
                            out_valid <= 1'b1;
                            wr_ptr    <= wr_ptr + 1'b1;
                        end
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    k   <= k + 1'b1;
                end
                ROUND: begin
                    data_out  <= sat;
                    out_valid <= 1'b1;
                    wr_ptr    <= wr_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lpf_fir_stage.sv
// Directed-vector bench for lpf_fir_stage (default build, TAPS=16).
module tb_lpf_fir_stage;

    typedef struct {
        logic signed [15:0] din;
        logic signed [15:0] exp;
        logic               chk;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] data_in = '0;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        ovr_clr = 1'b0;
    logic [15:0] data_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    int   total = 0;
    int   bad = 0;
    vec_t vecs [71];
    int   dc_exp [16];

    lpf_fir_stage dut (
        .clk       (clk),
        .rst_      (rst_),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .ovr_clr   (ovr_clr),
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one sample and wait (bounded) for its result; lat counts cycles from acceptance.
    task automatic run_one(input logic signed [15:0] s, output int y, output int lat);
        data_in  = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        y = $signed(data_out);
    endtask

    task automatic run_range(input int lo, input int hi, input string tag);
        int y, lat;
        for (int i = lo; i <= hi; i++) begin
            run_one(vecs[i].din, y, lat);
            check($sformatf("%s[%0d] latency", tag, i - lo), lat, 18);
            if (vecs[i].chk)
                check($sformatf("%s[%0d] data_out", tag, i - lo), y, int'(vecs[i].exp));
        end
    endtask

    task automatic wait_out(input int start, output int y, output int lat);
        lat = start;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        y = $signed(data_out);
    endtask

    initial begin
        int y, lat, nvld;

        dc_exp = '{63, 125, 188, 250, 313, 375, 438, 500,
                   563, 625, 688, 750, 813, 875, 938, 1000};
        // 0..31 impulse, 32..51 DC step, 52..54 positive saturation, 55..70 negative saturation
        for (int i = 0; i < 32; i++) begin
            vecs[i].din = (i == 0) ? 16'sd32767 : 16'sd0;
            vecs[i].exp = (i < 16) ? 16'sd2048 : 16'sd0;
            vecs[i].chk = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            vecs[32+i].din = 16'sd1000;
            vecs[32+i].exp = (i < 16) ? 16'(dc_exp[i]) : 16'sd1000;
            vecs[32+i].chk = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            vecs[52+i].din = 16'sd32767;
            vecs[52+i].exp = 16'sd32767;
            vecs[52+i].chk = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            vecs[55+i].din = -16'sd32768;
            vecs[55+i].exp = -16'sd32768;
            vecs[55+i].chk = (i >= 4);
        end

        // Reset held for 10 clocks
        repeat (10) tick();
        check("reset busy during", int'(busy), 0);
        rst_ = 1'b1;
        tick();
        check("reset data_out", int'(data_out), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset overrun", int'(overrun), 0);

        run_range(0, 31, "impulse");
        run_range(32, 51, "dc");

        for (int i = 0; i < 16; i++) begin
            coef_we   = 1'b1;
            coef_addr = 4'(i);
            coef_data = 16'd32767;
            tick();
        end
        coef_we = 1'b0;
        run_range(52, 70, "sat");

        // Reset restores default coefficients and clears the delay line
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
        tick();

        // Overrun: accept at cycle 0, second strobe at cycle 3 is dropped
        data_in  = 16'sd32767;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        data_in  = 16'sd12345;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("overrun set", int'(overrun), 1);
        wait_out(4, y, lat);
        check("overrun latency", lat, 18);
        check("overrun result", y, 2048);

        // Drop and clear in the same cycle: flag must stay set
        data_in  = 16'sd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b1;
        ovr_clr  = 1'b1;
        tick();
        in_valid = 1'b0;
        ovr_clr  = 1'b0;
        check("overrun clr vs drop", int'(overrun), 1);
        wait_out(2, y, lat);
        check("overrun 2nd result", y, 2048);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("overrun cleared", int'(overrun), 0);

        // Reset asserted mid-cycle during MAC, with overrun set
        data_in  = 16'sd5000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mid overrun before reset", int'(overrun), 1);
        repeat (6) tick();
        check("mid busy before reset", int'(busy), 1);
        #3;
        rst_ = 1'b0;
        #1;
        check("async rst data_out", int'(data_out), 0);
        check("async rst busy", int'(busy), 0);
        check("async rst overrun", int'(overrun), 0);
        check("async rst out_valid", int'(out_valid), 0);
        repeat (3) tick();
        rst_ = 1'b1;
        nvld = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) nvld++;
        end
        check("no out_valid after abort", nvld, 0);
        run_range(0, 17, "post-reset impulse");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lpf_fir_stage.md
Name: lpf_fir_stage

Overview:
- Time-multiplexed single-MAC FIR low-pass filter (LPF2). Sits directly upstream of the echo stage and drives its 16-bit signed data input.
- Accepts one signed 16-bit sample per in_valid strobe and convolves it with a programmable Q1.15 coefficient set.
- Holds the rounded, saturated result on data_out until the next result is ready.

Parameters:
- TAPS, 16, number of taps; power of two, 2..64.
- DW, 16, sample and output width (signed).
- CW, 16, coefficient width (signed Q1.15).
- ACCW, 40, accumulator width; must be at least DW+CW+log2(TAPS).

Ports:
- clk  in  1  system clock.
- rst_  in  1  asynchronous active-low reset.
- in_valid  in  1  sample strobe; single-cycle pulse.
- data_in  in  DW  signed input sample.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  log2(TAPS)  coefficient index k.
- coef_data  in  CW  signed Q1.15 coefficient h[k].
- ovr_clr  in  1  clears the overrun flag.
- data_out  out  DW  filtered sample (to echo stage data input).
- out_valid  out  1  one-cycle pulse when data_out updates.
- busy  out  1  high while a computation is in progress.
- overrun  out  1  sticky flag: a sample was dropped.

Behaviour:
- Reset (rst_ low, asynchronous), values while asserted:
  - data_out=0, out_valid=0, busy=0, overrun=0.
  - FSM=IDLE, wr_ptr=0, accumulator=0.
  - All TAPS delay-line entries = 0.
  - All coefficients = 16'sd2048 (1/16, i.e. 16-tap moving average).
- Delay line: circular buffer of TAPS samples.
  - On acceptance, data_in is written at wr_ptr; the tap read for index k is at (wr_ptr-k) mod TAPS.
  - wr_ptr increments after the MAC run, wrapping TAPS-1 -> 0.
- FSM states IDLE, MAC, ROUND; busy = (state != IDLE).
  - IDLE: in_valid=1 -> write sample, clear accumulator, k=0, go to MAC. The acceptance cycle is cycle 0.
  - MAC: one product per cycle, acc += x[n-k]*h[k] (full-precision signed, sign-extended to ACCW). Runs k=0..TAPS-1 over cycles 1..TAPS, then goes to ROUND.
  - ROUND (cycle TAPS+1):
    - r = (acc + 2^14) >>> 15 (arithmetic shift, round half toward +inf).
    - Saturate r to [-32768, 32767].
    - Register r into data_out, pulse out_valid, return to IDLE.
- Latency: out_valid is high in cycle TAPS+2 relative to the acceptance cycle. Maximum throughput is one sample per TAPS+2 cycles.
- data_out holds its value between updates; the downstream echo stage samples it as a level.
- in_valid while busy=1: sample dropped, overrun set to 1.
  - Overrun is sticky; cleared by ovr_clr=1 in a cycle with no new overrun event.
  - Simultaneous ovr_clr and a new drop: overrun stays 1.
- in_valid in the same cycle as the out_valid pulse (state is IDLE): accepted normally.
- coef_we is honoured only when busy=0; ignored while busy, with no flag raised.
- Simultaneous coef_we and in_valid in IDLE: the coefficient write takes effect first, so the new coefficient is used in this computation.
- rst_ asserted mid-MAC or mid-ROUND: computation is aborted, no out_valid is issued, and all reset values apply.

Optional Feature:
- Macro: LPF_BYPASS_EN.
- Defined:
  - Adds input port bypass (1 bit). bypass=1 in IDLE with in_valid: sample still written to the delay line and wr_ptr still advances.
  - MAC/ROUND are skipped; data_out = data_in and out_valid pulse in cycle 1 (latency 1); busy stays 0.
  - bypass is sampled only at acceptance.
- Undefined: no bypass port; every sample is filtered.

Test Plan:
- Reset: hold rst_=0 for 10 clk, then release -> data_out=0, out_valid=0, busy=0, overrun=0. Assert rst_ asynchronously mid-cycle -> outputs clear without waiting for a clock edge.
- Impulse, default coefficients: one sample 32767 followed by 31 zeros, spaced 18 cycles apart.
  - Each out_valid arrives 18 cycles after its in_valid.
  - data_out = 2048 for the first 16 outputs, then 0.
- DC step, default coefficients: constant 1000 -> outputs 63, 125, 188, ..., reaching 1000 at the 16th sample and holding at 1000.
- Saturation: write all coefficients to 32767, then feed constant 32767 -> data_out reaches 32767. Constant -32768 -> data_out = -32768; no wrap.
- Overrun: in_valid=1 at cycle 0 and again at cycle 3 -> second sample dropped, overrun=1, first result unchanged. ovr_clr for 1 cycle -> overrun=0.
- Reset mid-MAC: pulse rst_ low at cycle 8 of a computation -> no out_valid. The next impulse produces exactly the clean impulse-test response.
